// File: rtl/timer_pkg.sv
// Shared register map, control bits and FSM encoding for timer_irq_master.
// Snapshot states exist only when TIMER_MASTER_SNAPSHOT_EN is defined.
package timer_pkg;

  localparam logic [2:0] TMR_STATUS = 3'd0;
  localparam logic [2:0] TMR_CTRL   = 3'd1;
  localparam logic [2:0] TMR_PERL   = 3'd2;
  localparam logic [2:0] TMR_PERH   = 3'd3;
  localparam logic [2:0] TMR_SNAPL  = 3'd4;
  localparam logic [2:0] TMR_SNAPH  = 3'd5;

  localparam logic [15:0] CTRL_ITO   = 16'h0001;
  localparam logic [15:0] CTRL_CONT  = 16'h0002;
  localparam logic [15:0] CTRL_START = 16'h0004;
  localparam logic [15:0] CTRL_STOP  = 16'h0008;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_WR,
    OP_RD
  } bus_op_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_PL,
    S_WR_PH,
    S_GAP,
    S_WR_CTRL,
    S_ARMED,
    S_CLR,
    S_WR_STOP
`ifdef TIMER_MASTER_SNAPSHOT_EN
    ,
    S_SNAP_WR,
    S_RD_L,
    S_RD_L_CAP,
    S_RD_H_CAP
`endif
  } state_e;

endpackage

// File: rtl/timer_bus_if.sv
// Registered Avalon-MM strobe generator: one op in, one bus cycle out.
// Reads keep chipselect low; the address alone selects readdata.
module timer_bus_if
  import timer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  bus_op_e     op_i,
  input  logic [2:0]  addr_i,
  input  logic [15:0] data_i,
  output logic [2:0]  avm_address_o,
  output logic        avm_chipselect_o,
  output logic        avm_write_n_o,
  output logic [15:0] avm_writedata_o
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      avm_address_o    <= TMR_STATUS;
      avm_chipselect_o <= 1'b0;
      avm_write_n_o    <= 1'b1;
      avm_writedata_o  <= 16'h0;
    end else begin
      avm_chipselect_o <= (op_i == OP_WR);
      avm_write_n_o    <= (op_i != OP_WR);
      avm_address_o    <= (op_i == OP_NONE) ? TMR_STATUS : addr_i;
      avm_writedata_o  <= (op_i == OP_WR) ? data_i : 16'h0;
    end
  end

endmodule

// File: rtl/timer_irq_master.sv
// Hardware master that programs the interval timer and services timeouts.
// Define TIMER_MASTER_SNAPSHOT_EN to build the counter snapshot readback.
module timer_irq_master
  import timer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             continuous,
  input  logic [31:0]      period,
  input  logic             snap_req,
  input  logic             irq,
  output logic [2:0]       avm_address,
  output logic             avm_chipselect,
  output logic             avm_write_n,
  output logic [15:0]      avm_writedata,
  input  logic [15:0]      avm_readdata,
  output logic             busy,
  output logic             tick,
  output logic [CNT_W-1:0] tick_count,
  output logic [31:0]      snapshot,
  output logic             snap_valid
);

  state_e           state_q, state_d;
  bus_op_e          op;
  logic [2:0]       addr;
  logic [15:0]      wdata;
  logic [15:0]      per_hi_q;
  logic             cont_q, busy_q, tick_q, ign_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start_ok;

  assign start_ok = (state_q == S_IDLE) && start;

`ifdef TIMER_MASTER_SNAPSHOT_EN
  logic        snap_pend_q;
  logic [31:0] snap_q;
  logic        snap_valid_q;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (start) state_d = S_WR_PL;
      S_WR_PL:   state_d = stop ? S_WR_STOP : S_WR_PH;
      S_WR_PH:   state_d = stop ? S_WR_STOP : S_GAP;
      S_GAP:     state_d = stop ? S_WR_STOP : S_WR_CTRL;
      S_WR_CTRL: state_d = stop ? S_WR_STOP : S_ARMED;
      S_ARMED: begin
        if (stop)               state_d = S_WR_STOP;
        else if (irq && !ign_q) state_d = S_CLR;
`ifdef TIMER_MASTER_SNAPSHOT_EN
        else if (snap_pend_q)   state_d = S_SNAP_WR;
`endif
      end
      S_CLR: begin
        if (stop)        state_d = S_WR_STOP;
        else if (cont_q) state_d = S_ARMED;
        else             state_d = S_IDLE;
      end
      S_WR_STOP: state_d = S_IDLE;
`ifdef TIMER_MASTER_SNAPSHOT_EN
      S_SNAP_WR:  state_d = stop ? S_WR_STOP : S_RD_L;
      S_RD_L:     state_d = stop ? S_WR_STOP : S_RD_L_CAP;
      S_RD_L_CAP: state_d = stop ? S_WR_STOP : S_RD_H_CAP;
      S_RD_H_CAP: state_d = stop ? S_WR_STOP : S_ARMED;
`endif
      default:   state_d = S_IDLE;
    endcase
  end

  // Bus command is chosen for the state being entered so the
  // registered strobes line up with that state's cycle.
  always_comb begin
    op    = OP_NONE;
    addr  = TMR_STATUS;
    wdata = 16'h0;
    unique case (state_d)
      S_WR_PL: begin
        op    = OP_WR;
        addr  = TMR_PERL;
        wdata = period[15:0];
      end
      S_WR_PH: begin
        op    = OP_WR;
        addr  = TMR_PERH;
        wdata = per_hi_q;
      end
      S_WR_CTRL: begin
        op    = OP_WR;
        addr  = TMR_CTRL;
        wdata = cont_q ? (CTRL_START | CTRL_CONT | CTRL_ITO)
                       : (CTRL_START | CTRL_ITO);
      end
      S_CLR: begin
        op    = OP_WR;
        addr  = TMR_STATUS;
      end
      S_WR_STOP: begin
        op    = OP_WR;
        addr  = TMR_CTRL;
        wdata = CTRL_STOP;
      end
`ifdef TIMER_MASTER_SNAPSHOT_EN
      S_SNAP_WR: begin
        op    = OP_WR;
        addr  = TMR_SNAPL;
      end
      S_RD_L: begin
        op    = OP_RD;
        addr  = TMR_SNAPL;
      end
      S_RD_L_CAP: begin
        op    = OP_RD;
        addr  = TMR_SNAPH;
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (start_ok)
      cnt_d = '0;
    else if (state_d == S_CLR)
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      per_hi_q <= 16'h0;
      cont_q   <= 1'b0;
      busy_q   <= 1'b0;
      tick_q   <= 1'b0;
      ign_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != S_IDLE);
      tick_q  <= (state_d == S_CLR);
      ign_q   <= (state_q == S_CLR);
      cnt_q   <= cnt_d;
      if (start_ok) begin
        per_hi_q <= period[31:16];
        cont_q   <= continuous;
      end
    end
  end

`ifdef TIMER_MASTER_SNAPSHOT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_pend_q  <= 1'b0;
      snap_q       <= 32'h0;
      snap_valid_q <= 1'b0;
    end else begin
      if (state_d == S_SNAP_WR || state_d == S_IDLE)
        snap_pend_q <= 1'b0;
      else if (snap_req && state_q != S_IDLE)
        snap_pend_q <= 1'b1;
      if (state_q == S_RD_L_CAP)
        snap_q[15:0] <= avm_readdata;
      if (state_q == S_RD_H_CAP)
        snap_q[31:16] <= avm_readdata;
      snap_valid_q <= (state_q == S_RD_H_CAP);
    end
  end

  assign snapshot   = snap_q;
  assign snap_valid = snap_valid_q;
`else
  logic unused_snap;
  assign unused_snap = snap_req ^ (^avm_readdata);
  assign snapshot    = 32'h0;
  assign snap_valid  = 1'b0;
`endif

  timer_bus_if u_bus (
    .clk              (clk),
    .reset            (reset),
    .op_i             (op),
    .addr_i           (addr),
    .data_i           (wdata),
    .avm_address_o    (avm_address),
    .avm_chipselect_o (avm_chipselect),
    .avm_write_n_o    (avm_write_n),
    .avm_writedata_o  (avm_writedata)
  );

  assign busy       = busy_q;
  assign tick       = tick_q;
  assign tick_count = cnt_q;

endmodule

// File: tb/tb_timer_irq_master.sv
// Directed bench for timer_irq_master with a small interval timer model.
// Snapshot scenarios run only when TIMER_MASTER_SNAPSHOT_EN is defined.
module tb_timer_irq_master;

  localparam int CW = 3;
  localparam logic [20:0] BUS_IDLE = {1'b0, 1'b1, 3'd0, 16'h0};

  logic          clk = 1'b0;
  logic          reset;
  logic          start, stop, continuous, snap_req;
  logic [31:0]   period;
  wire           irq;
  logic [2:0]    avm_address;
  logic          avm_chipselect, avm_write_n;
  logic [15:0]   avm_writedata;
  wire  [15:0]   avm_readdata;
  logic          busy, tick, snap_valid;
  logic [CW-1:0] tick_count;
  logic [31:0]   snapshot;
  logic [20:0]   bus;

  logic        model_en, irq_drv;
  logic [31:0] snap_val;

  int n_cmp = 0;
  int n_bad = 0;
  int n_wr = 0, n_clr = 0, n_tick = 0, n_sv = 0, bad_seq = 0, clr_gap = 0;

  always #5 clk = ~clk;

  timer_irq_master #(.CNT_W(CW)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .stop           (stop),
    .continuous     (continuous),
    .period         (period),
    .snap_req       (snap_req),
    .irq            (irq),
    .avm_address    (avm_address),
    .avm_chipselect (avm_chipselect),
    .avm_write_n    (avm_write_n),
    .avm_writedata  (avm_writedata),
    .avm_readdata   (avm_readdata),
    .busy           (busy),
    .tick           (tick),
    .tick_count     (tick_count),
    .snapshot       (snapshot),
    .snap_valid     (snap_valid)
  );

  assign bus = {avm_chipselect, avm_write_n, avm_address, avm_writedata};

  // Interval timer model: countdown, timeout flag, registered irq/readdata.
  logic [15:0] m_pl, m_ph, m_rd;
  logic [31:0] m_cnt;
  logic        m_run, m_cont, m_to, m_irq;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pl <= 0; m_ph <= 0; m_rd <= 0; m_cnt <= 0;
      m_run <= 0; m_cont <= 0; m_to <= 0; m_irq <= 0;
    end else begin
      m_irq <= m_to;
      m_rd  <= (avm_address == 3'd4) ? snap_val[15:0] :
               (avm_address == 3'd5) ? snap_val[31:16] : 16'h0;
      if (avm_chipselect && !avm_write_n) begin
        case (avm_address)
          3'd0: m_to <= 1'b0;
          3'd1: begin
            if (avm_writedata[2]) begin
              m_run  <= 1'b1;
              m_cont <= avm_writedata[1];
              m_cnt  <= {m_ph, m_pl};
            end else if (avm_writedata[3]) begin
              m_run <= 1'b0;
            end
          end
          3'd2: m_pl <= avm_writedata;
          3'd3: m_ph <= avm_writedata;
          default: ;
        endcase
      end else if (m_run) begin
        if (m_cnt == 0) begin
          m_to  <= 1'b1;
          m_cnt <= {m_ph, m_pl};
          m_run <= m_cont;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end
  end

  assign irq          = model_en ? m_irq : irq_drv;
  assign avm_readdata = m_rd;

  always @(negedge clk) begin
    if (avm_chipselect && !avm_write_n) begin
      n_wr++;
      if (avm_address == 3'd0) begin
        n_clr++;
        clr_gap++;
      end
    end
    if (tick) begin
      n_tick++;
      if (clr_gap != 1) bad_seq++;
      clr_gap = 0;
    end
    if (snap_valid) n_sv++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 0; stop = 0; continuous = 0;
    period = 0; snap_req = 0; irq_drv = 0; model_en = 0;
    snap_val = 0;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic arm(input logic [31:0] per, input logic cont);
    period = per; continuous = cont; start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    n_cmp++;
    if (bus !== BUS_IDLE) begin
      n_bad++; $display("FAIL rst_bus got %h exp %h", bus, BUS_IDLE);
    end
    n_cmp++;
    if ({busy, tick, snap_valid} !== 3'b000) begin
      n_bad++;
      $display("FAIL rst_flags got %b exp 000", {busy, tick, snap_valid});
    end
    n_cmp++;
    if (tick_count !== '0) begin
      n_bad++; $display("FAIL rst_count got %h exp 0", tick_count);
    end
    n_cmp++;
    if (snapshot !== 32'h0) begin
      n_bad++; $display("FAIL rst_snap got %h exp 0", snapshot);
    end
    do_reset();
  endtask

  task automatic test_oneshot();
    do_reset();
    period = 32'h0000_0009; continuous = 0; start = 1'b1;
    step();
    start = 1'b0;
    n_cmp++;
    if (bus !== {1'b1, 1'b0, 3'd2, 16'h0009}) begin
      n_bad++; $display("FAIL os_perl got %h", bus);
    end
    step();
    n_cmp++;
    if (bus !== {1'b1, 1'b0, 3'd3, 16'h0000}) begin
      n_bad++; $display("FAIL os_perh got %h", bus);
    end
    step();
    n_cmp++;
    if ({bus, busy} !== {BUS_IDLE, 1'b1}) begin
      n_bad++; $display("FAIL os_gap got %h busy %b", bus, busy);
    end
    step();
    n_cmp++;
    if (bus !== {1'b1, 1'b0, 3'd1, 16'h0005}) begin
      n_bad++; $display("FAIL os_ctrl got %h exp ctrl 5", bus);
    end
    step();
    n_cmp++;
    if ({bus, busy} !== {BUS_IDLE, 1'b1}) begin
      n_bad++; $display("FAIL os_armed got %h busy %b", bus, busy);
    end
    irq_drv = 1'b1;
    step();
    irq_drv = 1'b0;
    n_cmp++;
    if ({bus, tick} !== {1'b1, 1'b0, 3'd0, 16'h0, 1'b1}) begin
      n_bad++; $display("FAIL os_clr got %h tick %b", bus, tick);
    end
    n_cmp++;
    if (tick_count !== 3'd1) begin
      n_bad++; $display("FAIL os_count got %0d exp 1", tick_count);
    end
    step();
    n_cmp++;
    if ({busy, tick} !== 2'b00) begin
      n_bad++; $display("FAIL os_done got %b exp 00", {busy, tick});
    end
  endtask

  task automatic test_continuous();
    int t0, c0, b0;
    do_reset();
    model_en = 1'b1;
    t0 = n_tick; c0 = n_clr; b0 = bad_seq;
    period = 32'd4; continuous = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 300 && n_tick - t0 < 5; i++) step();
    n_cmp++;
    if (n_tick - t0 !== 5 || tick_count !== 3'd5) begin
      n_bad++;
      $display("FAIL cont_5 ticks %0d count %0d exp 5",
               n_tick - t0, tick_count);
    end
    for (int i = 0; i < 300 && n_tick - t0 < 9; i++) step();
    n_cmp++;
    if (tick_count !== 3'd1) begin
      n_bad++; $display("FAIL cont_wrap got %0d exp 1", tick_count);
    end
    n_cmp++;
    if (n_clr - c0 !== 9 || bad_seq - b0 !== 0) begin
      n_bad++;
      $display("FAIL cont_seq clr %0d badseq %0d exp 9/0",
               n_clr - c0, bad_seq - b0);
    end
  endtask

  task automatic test_stop_armed();
    int w0, c0;
    do_reset();
    model_en = 1'b1;
    arm(32'd1000, 1'b1);
    period = 32'h55; start = 1'b1;
    step();
    start = 1'b0;
    n_cmp++;
    if ({bus, busy} !== {BUS_IDLE, 1'b1}) begin
      n_bad++; $display("FAIL busy_start got %h busy %b", bus, busy);
    end
    w0 = n_wr; c0 = n_clr;
    stop = 1'b1;
    step();
    stop = 1'b0;
    n_cmp++;
    if (bus !== {1'b1, 1'b0, 3'd1, 16'h0008}) begin
      n_bad++; $display("FAIL stop_wr got %h exp ctrl 8", bus);
    end
    model_en = 1'b0;
    irq_drv = 1'b1;
    repeat (5) step();
    irq_drv = 1'b0;
    n_cmp++;
    if (n_wr - w0 !== 1 || n_clr - c0 !== 0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL stop_after wr %0d clr %0d busy %b exp 1/0/0",
               n_wr - w0, n_clr - c0, busy);
    end
  endtask

`ifdef TIMER_MASTER_SNAPSHOT_EN
  task automatic test_snapshot();
    int s0;
    do_reset();
    snap_val = 32'h0001_2345;
    arm(32'd1000, 1'b1);
    s0 = n_sv;
    snap_req = 1'b1;
    step();
    snap_req = 1'b0;
    step();
    n_cmp++;
    if (bus !== {1'b1, 1'b0, 3'd4, 16'h0}) begin
      n_bad++; $display("FAIL snap_wr got %h", bus);
    end
    step();
    n_cmp++;
    if (bus !== {1'b0, 1'b1, 3'd4, 16'h0}) begin
      n_bad++; $display("FAIL snap_rdl got %h", bus);
    end
    step();
    n_cmp++;
    if (bus !== {1'b0, 1'b1, 3'd5, 16'h0}) begin
      n_bad++; $display("FAIL snap_rdh got %h", bus);
    end
    step();
    step();
    n_cmp++;
    if ({snap_valid, snapshot} !== {1'b1, 32'h0001_2345}) begin
      n_bad++;
      $display("FAIL snap_val got %b %h", snap_valid, snapshot);
    end
    step();
    n_cmp++;
    if (n_sv - s0 !== 1) begin
      n_bad++; $display("FAIL snap_once got %0d exp 1", n_sv - s0);
    end
  endtask

  task automatic test_irq_and_snap();
    int s0, c0;
    do_reset();
    snap_val = 32'hBEEF_0042;
    arm(32'd1000, 1'b1);
    s0 = n_sv; c0 = n_clr;
    irq_drv = 1'b1; snap_req = 1'b1;
    step();
    snap_req = 1'b0;
    n_cmp++;
    if ({bus, tick} !== {1'b1, 1'b0, 3'd0, 16'h0, 1'b1}) begin
      n_bad++; $display("FAIL both_clr got %h tick %b", bus, tick);
    end
    step();
    step();
    irq_drv = 1'b0;
    n_cmp++;
    if (bus !== {1'b1, 1'b0, 3'd4, 16'h0}) begin
      n_bad++; $display("FAIL both_snapwr got %h", bus);
    end
    for (int i = 0; i < 10 && n_sv == s0; i++) step();
    n_cmp++;
    if (n_sv - s0 !== 1 || tick_count !== 3'd1 || n_clr - c0 !== 1) begin
      n_bad++;
      $display("FAIL both_done sv %0d count %0d clr %0d exp 1/1/1",
               n_sv - s0, tick_count, n_clr - c0);
    end
    n_cmp++;
    if (snapshot !== 32'hBEEF_0042) begin
      n_bad++; $display("FAIL both_snap got %h", snapshot);
    end
  endtask
`else
  task automatic test_snap_disabled();
    int w0, s0;
    do_reset();
    snap_val = 32'h0001_2345;
    arm(32'd1000, 1'b1);
    w0 = n_wr; s0 = n_sv;
    snap_req = 1'b1;
    step();
    snap_req = 1'b0;
    repeat (6) step();
    n_cmp++;
    if (n_wr - w0 !== 0 || n_sv - s0 !== 0) begin
      n_bad++;
      $display("FAIL nosnap_bus wr %0d sv %0d exp 0/0",
               n_wr - w0, n_sv - s0);
    end
    n_cmp++;
    if (snapshot !== 32'h0) begin
      n_bad++; $display("FAIL nosnap_val got %h exp 0", snapshot);
    end
  endtask
`endif

  task automatic test_reset_mid();
    int w0;
    do_reset();
    period = 32'h1234_5678; continuous = 0; start = 1'b1;
    step();
    start = 1'b0;
    n_cmp++;
    if (bus !== {1'b1, 1'b0, 3'd2, 16'h5678}) begin
      n_bad++; $display("FAIL mid_perl got %h", bus);
    end
    step();
    n_cmp++;
    if (bus !== {1'b1, 1'b0, 3'd3, 16'h1234}) begin
      n_bad++; $display("FAIL mid_perh got %h", bus);
    end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({bus, busy} !== {BUS_IDLE, 1'b0}) begin
      n_bad++; $display("FAIL mid_async got %h busy %b", bus, busy);
    end
    step();
    reset = 1'b0;
    w0 = n_wr;
    repeat (8) step();
    n_cmp++;
    if (n_wr - w0 !== 0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_quiet wr %0d busy %b exp 0/0", n_wr - w0, busy);
    end
    period = 32'd7; continuous = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    n_cmp++;
    if ({bus, busy} !== {1'b1, 1'b0, 3'd2, 16'h0007, 1'b1}) begin
      n_bad++; $display("FAIL mid_restart got %h busy %b", bus, busy);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 0; stop = 0; continuous = 0;
    period = 0; snap_req = 0; irq_drv = 0; model_en = 0;
    snap_val = 0;
    test_reset();
    test_oneshot();
    test_continuous();
    test_stop_armed();
`ifdef TIMER_MASTER_SNAPSHOT_EN
    test_snapshot();
    test_irq_and_snap();
`else
    test_snap_disabled();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
